// File: rtl/cdb_writeback_arbiter_if.sv
// Bus bundle between the functional units and the CDB writeback arbiter.
// master: FU/issue side (drives finish pulses, observes CDB and queue status).
// slave:  arbiter side (consumes finish pulses, drives CDB and queue status).
interface cdb_writeback_arbiter_if #(
   parameter int N_FU  = 5,
   parameter int TAG_W = 4,
   parameter int SRC_W = 3
);
   logic [N_FU-1:0]       fu_finish;
   logic [N_FU*32-1:0]    fu_res;
   logic [N_FU*TAG_W-1:0] fu_tag;
   logic                  cdb_valid;
   logic [SRC_W-1:0]      cdb_src;
   logic [TAG_W-1:0]      cdb_tag;
   logic [31:0]           cdb_data;
   logic [N_FU-1:0]       fu_full;
   logic                  ovf_err;

   modport master (
      output fu_finish, fu_res, fu_tag,
      input  cdb_valid, cdb_src, cdb_tag, cdb_data, fu_full, ovf_err
   );

   modport slave (
      input  fu_finish, fu_res, fu_tag,
      output cdb_valid, cdb_src, cdb_tag, cdb_data, fu_full, ovf_err
   );
endinterface

// File: rtl/cdb_writeback_arbiter.sv
// CDB writeback arbiter: captures one-cycle FU completion pulses into
// per-FU FIFOs and broadcasts one result per cycle on the common data bus.
// Optional macro CDB_RR_EN selects round-robin arbitration; when it is not
// defined, the lowest-index non-empty queue always wins.
module cdb_writeback_arbiter #(
   parameter int N_FU  = 5,
   parameter int TAG_W = 4,
   parameter int SRC_W = 3,
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   cdb_writeback_arbiter_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = TAG_W + 32;

   logic [N_FU-1:0]  req;
   logic [N_FU-1:0]  pop;
   logic [N_FU-1:0]  drop;
   logic [N_FU-1:0]  full;
   logic [ENT_W-1:0] head [N_FU];
   logic             any_req;
   logic [SRC_W-1:0] grant;

   logic             cdb_valid_q, cdb_valid_d;
   logic [SRC_W-1:0] cdb_src_q,   cdb_src_d;
   logic [TAG_W-1:0] cdb_tag_q,   cdb_tag_d;
   logic [31:0]      cdb_data_q,  cdb_data_d;
   logic             ovf_err_q,   ovf_err_d;

   // One FIFO per functional unit; a full queue still accepts a push when it
   // is being popped at the same edge, since the count does not change.
   for (genvar gi = 0; gi < N_FU; gi++) begin : g_queue
      logic [ENT_W-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] cnt_q,    cnt_d;
      logic             push_ok;

      // Pointer/count next state from accepted push and granted pop.
      always_comb begin
         push_ok  = bus.fu_finish[gi] && ((cnt_q != CNT_W'(DEPTH)) || pop[gi]);
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         cnt_d    = cnt_q;
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop[gi]) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop[gi]})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end

      // Queue control registers; reset empties the queue.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
         end
      end

      // Entry storage; contents need no reset because the count gates use.
      always_ff @(posedge clk) begin
         if (rst_n && push_ok) begin
            mem_q[wr_ptr_q] <= {bus.fu_tag[gi*TAG_W +: TAG_W], bus.fu_res[gi*32 +: 32]};
         end
      end

      assign req[gi]  = (cnt_q != '0);
      assign full[gi] = (cnt_q == CNT_W'(DEPTH));
      assign drop[gi] = bus.fu_finish[gi] & ~push_ok;
      assign head[gi] = mem_q[rd_ptr_q];
   end

   assign any_req = |req;

`ifdef CDB_RR_EN
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0] rr_idx;
   logic             rr_found;

   // Round-robin search starting just after the last granted source.
   always_comb begin
      grant    = '0;
      rr_found = 1'b0;
      rr_idx   = '0;
      for (int k = 1; k <= N_FU; k++) begin
         rr_idx = SRC_W'((int'(rr_ptr_q) + k) % N_FU);
         if (!rr_found && req[rr_idx]) begin
            grant    = rr_idx;
            rr_found = 1'b1;
         end
      end
      rr_ptr_d = any_req ? grant : rr_ptr_q;
   end

   // Last-granted pointer; starts at N_FU-1 so source 0 is searched first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr_q <= SRC_W'(N_FU - 1);
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      grant = '0;
      for (int i = N_FU - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant = SRC_W'(i);
         end
      end
   end
`endif

   // Decode the grant into a one-hot pop.
   always_comb begin
      pop = '0;
      if (any_req) begin
         pop[grant] = 1'b1;
      end
   end

   // CDB next state: load the granted head, otherwise hold payload and drop valid.
   always_comb begin
      cdb_valid_d = any_req;
      cdb_src_d   = cdb_src_q;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
      if (any_req) begin
         cdb_src_d               = grant;
         {cdb_tag_d, cdb_data_d} = head[grant];
      end
      ovf_err_d = ovf_err_q | (|drop);
   end

   // Registered CDB outputs and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= '0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         ovf_err_q   <= 1'b0;
      end else begin
         cdb_valid_q <= cdb_valid_d;
         cdb_src_q   <= cdb_src_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_data_q  <= cdb_data_d;
         ovf_err_q   <= ovf_err_d;
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_src   = cdb_src_q;
   assign bus.cdb_tag   = cdb_tag_q;
   assign bus.cdb_data  = cdb_data_q;
   assign bus.fu_full   = full;
   assign bus.ovf_err   = ovf_err_q;
endmodule
